// File: rtl/spi_master_multi.sv
// SPI master: configurable word width, chip-select count, CPOL/CPHA, bit order and SCK divider.
// Requests arrive over valid/ready; cs_hold keeps the slave selected across consecutive words.
module spi_master_multi #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CS     = 2,
  parameter int DIV_WIDTH  = 8,
  localparam int CS_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic [CS_W-1:0]       cs_sel,
  input  logic                  cs_hold,
  input  logic                  release_cs,
  input  logic [DIV_WIDTH-1:0]  cfg_div,
  input  logic                  cfg_cpol,
  input  logic                  cfg_cpha,
  input  logic                  cfg_lsb_first,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  spi_clk,
  output logic                  spi_mosi,
  input  logic                  spi_miso,
  output logic [NUM_CS-1:0]     spi_ce_n
);

  localparam int EW = $clog2(2 * DATA_WIDTH);
  localparam logic [EW-1:0] LAST_HP = EW'(2 * DATA_WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_DONE, S_GAP, S_HOLD} state_t;

  state_t                state_q, state_d;
  logic [DIV_WIDTH-1:0]  cnt_q, cnt_d, div_q, div_d;
  logic [EW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d, rx_data_q, rx_data_d;
  logic [CS_W-1:0]       cs_idx_q, cs_idx_d;
  logic [NUM_CS-1:0]     ce_n_q, ce_n_d;
  logic                  cpha_q, cpha_d, lsb_q, lsb_d, hold_q, hold_d;
  logic                  sclk_q, sclk_d, mosi_q, mosi_d, rx_valid_q, rx_valid_d;

  logic                  accept, hp_end, edge_en;
  logic [EW-1:0]         edge_idx;
  logic [DATA_WIDTH-1:0] tx_shifted;

  // An out-of-range index matches no line, so every chip select stays high.
  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
    logic [NUM_CS-1:0] r;
    for (int i = 0; i < NUM_CS; i++) r[i] = (int'(sel) != i);
    return r;
  endfunction

  function automatic logic out_bit(input logic [DATA_WIDTH-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_WIDTH-1];
  endfunction

  assign tx_ready   = (state_q == S_IDLE) || (state_q == S_HOLD);
  assign accept     = tx_valid && tx_ready;
  assign hp_end     = (cnt_q == '0);
  assign tx_shifted = lsb_q ? (tx_sr_q >> 1) : (tx_sr_q << 1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    idx_d      = idx_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    cs_idx_d   = cs_idx_q;
    ce_n_d     = ce_n_q;
    cpha_d     = cpha_q;
    lsb_d      = lsb_q;
    hold_d     = hold_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    rx_valid_d = 1'b0;
    edge_en    = 1'b0;
    edge_idx   = '0;

    case (state_q)
      S_IDLE, S_HOLD: begin
        if (accept) begin
          cpha_d  = cfg_cpha;
          lsb_d   = cfg_lsb_first;
          div_d   = cfg_div;
          cnt_d   = cfg_div;
          hold_d  = cs_hold;
          tx_sr_d = tx_data;
          sclk_d  = cfg_cpol;
          // A word continued from HOLD keeps the slave that was selected first.
          if (state_q == S_IDLE) begin
            cs_idx_d = cs_sel;
            ce_n_d   = cs_decode(cs_sel);
          end
          if (!cfg_cpha) mosi_d = out_bit(tx_data, cfg_lsb_first);
          state_d = S_SETUP;
        end else if ((state_q == S_HOLD) && release_cs) begin
          ce_n_d  = '1;
          cnt_d   = div_q;
          state_d = S_GAP;
        end
      end
      S_SETUP: begin
        if (hp_end) begin
          sclk_d   = ~sclk_q;
          cnt_d    = div_q;
          idx_d    = '0;
          edge_en  = 1'b1;
          edge_idx = '0;
          state_d  = S_SHIFT;
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
      S_SHIFT: begin
        if (hp_end) begin
          cnt_d = div_q;
          if (idx_q == LAST_HP) begin
            state_d = S_DONE;
          end else begin
            sclk_d   = ~sclk_q;
            idx_d    = idx_q + EW'(1);
            edge_en  = 1'b1;
            edge_idx = idx_q + EW'(1);
          end
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
      S_DONE: begin
        if (hp_end) begin
          rx_data_d  = rx_sr_q;
          rx_valid_d = 1'b1;
          cnt_d      = div_q;
          if (hold_q) begin
            state_d = S_HOLD;
          end else begin
            ce_n_d  = '1;
            state_d = S_GAP;
          end
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
      S_GAP: begin
        if (hp_end) state_d = S_IDLE;
        else        cnt_d   = cnt_q - DIV_WIDTH'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // Even edge index = leading SCK edge; sampling happens on the edge whose parity equals CPHA.
    if (edge_en) begin
      if (edge_idx[0] == cpha_q) begin
        rx_sr_d = lsb_q ? {spi_miso, rx_sr_q[DATA_WIDTH-1:1]}
                        : {rx_sr_q[DATA_WIDTH-2:0], spi_miso};
      end else if (cpha_q && (edge_idx == '0)) begin
        mosi_d = out_bit(tx_sr_q, lsb_q);
      end else if (edge_idx != LAST_HP) begin
        tx_sr_d = tx_shifted;
        mosi_d  = out_bit(tx_shifted, lsb_q);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      idx_q      <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      cs_idx_q   <= '0;
      ce_n_q     <= '1;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      hold_q     <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      idx_q      <= idx_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      cs_idx_q   <= cs_idx_d;
      ce_n_q     <= ce_n_d;
      cpha_q     <= cpha_d;
      lsb_q      <= lsb_d;
      hold_q     <= hold_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = (state_q != S_IDLE);
  assign spi_clk  = sclk_q;
  assign spi_mosi = mosi_q;
  assign spi_ce_n = ce_n_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// Directed bench for spi_master_multi: loopback and scripted-slave transfers, hold/release, async reset.
// A second instance with three chip selects exercises an out-of-range cs_sel.
module tb_spi_master_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid, tx_valid2;
  logic       tx_ready, tx_ready2;
  logic [7:0] tx_data;
  logic       cs_sel;
  logic [1:0] cs_sel2;
  logic       cs_hold, release_cs;
  logic [7:0] cfg_div;
  logic       cfg_cpol, cfg_cpha, cfg_lsb_first;
  logic [7:0] rx_data, rx_data2;
  logic       rx_valid, rx_valid2, busy, busy2;
  logic       spi_clk, spi_clk2, spi_mosi, spi_mosi2, spi_miso;
  logic [1:0] spi_ce_n;
  logic [2:0] spi_ce_n2;

  int tests = 0;
  int fails = 0;

  logic       loop_mode;
  logic       slv_bit;
  logic [7:0] slv_word;
  int         slv_cnt;

  always #5 clk = ~clk;

  assign spi_miso = loop_mode ? spi_mosi : slv_bit;

  // Scripted slave: presents its next bit on every falling SCK edge.
  always @(negedge spi_clk) begin
    if (!loop_mode) begin
      slv_bit = slv_word[slv_cnt[2:0]];
      slv_cnt++;
    end
  end

  spi_master_multi dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .cs_sel(cs_sel), .cs_hold(cs_hold), .release_cs(release_cs), .cfg_div(cfg_div),
    .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha), .cfg_lsb_first(cfg_lsb_first),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_ce_n(spi_ce_n)
  );

  spi_master_multi #(.NUM_CS(3)) dut3 (
    .clk(clk), .rst(rst), .tx_valid(tx_valid2), .tx_ready(tx_ready2), .tx_data(tx_data),
    .cs_sel(cs_sel2), .cs_hold(cs_hold), .release_cs(release_cs), .cfg_div(cfg_div),
    .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha), .cfg_lsb_first(cfg_lsb_first),
    .rx_data(rx_data2), .rx_valid(rx_valid2), .busy(busy2), .spi_clk(spi_clk2),
    .spi_mosi(spi_mosi2), .spi_miso(spi_miso), .spi_ce_n(spi_ce_n2)
  );

  // Called 1 time unit after a rising edge; returns 1 unit after the accepting edge,
  // then scrambles every request field so only latched values can be used.
  task automatic send(input logic [7:0] d, input logic sel, input logic hold,
                      input logic [7:0] div, input logic cpol, input logic cpha, input logic lsb);
    tx_data = d; cs_sel = sel; cs_hold = hold; cfg_div = div;
    cfg_cpol = cpol; cfg_cpha = cpha; cfg_lsb_first = lsb;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    tx_data = ~d; cs_sel = ~sel; cs_hold = ~hold; cfg_div = div + 8'd3;
    cfg_cpol = ~cpol; cfg_cpha = ~cpha; cfg_lsb_first = ~lsb;
  endtask

  task automatic test_reset();
    #12;
    tests++; if (spi_ce_n !== 2'b11) begin fails++; $display("FAIL rst_ce_n: got %b expected 11", spi_ce_n); end
    tests++; if (spi_clk !== 1'b0) begin fails++; $display("FAIL rst_spi_clk: got %b expected 0", spi_clk); end
    tests++; if (spi_mosi !== 1'b0) begin fails++; $display("FAIL rst_mosi: got %b expected 0", spi_mosi); end
    tests++; if (rx_data !== 8'h00) begin fails++; $display("FAIL rst_rx_data: got %h expected 00", rx_data); end
    tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL rst_rx_valid: got %b expected 0", rx_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b expected 0", busy); end
    @(posedge clk); #1;
    rst = 1'b0;
    #2;
    tests++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL rst_tx_ready: got %b expected 1", tx_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_loopback_mode0();
    logic prev;
    int   rises;
    logic [1:0] exp_ce;
    loop_mode = 1'b1;
    rises = 0;
    send(8'hA5, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    prev = spi_clk;
    tests++; if (spi_ce_n !== 2'b01) begin fails++; $display("FAIL m0_ce_n n=0: got %b expected 01", spi_ce_n); end
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (spi_clk && !prev) rises++;
      prev = spi_clk;
      exp_ce = (n <= 17) ? 2'b01 : 2'b11;
      tests++; if (spi_ce_n !== exp_ce) begin fails++; $display("FAIL m0_ce_n n=%0d: got %b expected %b", n, spi_ce_n, exp_ce); end
      tests++; if (rx_valid !== (n == 18)) begin fails++; $display("FAIL m0_rx_valid n=%0d: got %b expected %b", n, rx_valid, (n == 18)); end
      if (n == 18) begin
        tests++; if (rx_data !== 8'hA5) begin fails++; $display("FAIL m0_rx_data: got %h expected a5", rx_data); end
        tests++; if (tx_ready !== 1'b0) begin fails++; $display("FAIL m0_gap_ready: got %b expected 0", tx_ready); end
      end
      if (n == 19) begin
        tests++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL m0_idle_ready: got %b expected 1", tx_ready); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL m0_idle_busy: got %b expected 0", busy); end
      end
    end
    tests++; if (rises !== 8) begin fails++; $display("FAIL m0_rising_edges: got %0d expected 8", rises); end
  endtask

  task automatic test_mode3_lsb();
    loop_mode = 1'b0;
    slv_word  = 8'h80;
    slv_cnt   = 0;
    send(8'h01, 1'b0, 1'b0, 8'd3, 1'b1, 1'b1, 1'b1);
    tests++; if (spi_clk !== 1'b1) begin fails++; $display("FAIL m3_setup_clk: got %b expected 1", spi_clk); end
    tests++; if (spi_ce_n !== 2'b10) begin fails++; $display("FAIL m3_ce_n: got %b expected 10", spi_ce_n); end
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk); #1;
      if (n == 4) begin
        tests++; if (spi_mosi !== 1'b1) begin fails++; $display("FAIL m3_first_bit: got %b expected 1", spi_mosi); end
      end
      if (n == 12) begin
        tests++; if (spi_mosi !== 1'b0) begin fails++; $display("FAIL m3_second_bit: got %b expected 0", spi_mosi); end
      end
      tests++; if (rx_valid !== (n == 72)) begin fails++; $display("FAIL m3_rx_valid n=%0d: got %b expected %b", n, rx_valid, (n == 72)); end
      if (n == 72) begin
        tests++; if (rx_data !== 8'h80) begin fails++; $display("FAIL m3_rx_data: got %h expected 80", rx_data); end
      end
    end
    tests++; if (spi_clk !== 1'b1) begin fails++; $display("FAIL m3_idle_clk: got %b expected 1", spi_clk); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL m3_idle_busy: got %b expected 0", busy); end
    loop_mode = 1'b1;
  endtask

  task automatic test_hold();
    logic [1:0] exp_ce;
    send(8'h12, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
    for (int n = 1; n <= 18; n++) begin
      @(posedge clk); #1;
      tests++; if (spi_ce_n !== 2'b10) begin fails++; $display("FAIL hold_ce1 n=%0d: got %b expected 10", n, spi_ce_n); end
    end
    tests++; if (rx_valid !== 1'b1) begin fails++; $display("FAIL hold_rx_valid1: got %b expected 1", rx_valid); end
    tests++; if (rx_data !== 8'h12) begin fails++; $display("FAIL hold_rx_data1: got %h expected 12", rx_data); end
    tests++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL hold_tx_ready: got %b expected 1", tx_ready); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL hold_busy: got %b expected 1", busy); end
    send(8'h34, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    tests++; if (spi_ce_n !== 2'b10) begin fails++; $display("FAIL hold_ce2 m=0: got %b expected 10", spi_ce_n); end
    for (int m = 1; m <= 20; m++) begin
      @(posedge clk); #1;
      exp_ce = (m <= 17) ? 2'b10 : 2'b11;
      tests++; if (spi_ce_n !== exp_ce) begin fails++; $display("FAIL hold_ce2 m=%0d: got %b expected %b", m, spi_ce_n, exp_ce); end
      if (m == 18) begin
        tests++; if (rx_valid !== 1'b1) begin fails++; $display("FAIL hold_rx_valid2: got %b expected 1", rx_valid); end
        tests++; if (rx_data !== 8'h34) begin fails++; $display("FAIL hold_rx_data2: got %h expected 34", rx_data); end
      end
    end
  endtask

  task automatic test_release();
    send(8'h3C, 1'b1, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0);
    repeat (36) begin @(posedge clk); #1; end
    tests++; if (rx_valid !== 1'b1) begin fails++; $display("FAIL rel_rx_valid: got %b expected 1", rx_valid); end
    tests++; if (spi_ce_n !== 2'b01) begin fails++; $display("FAIL rel_ce_held: got %b expected 01", spi_ce_n); end
    release_cs = 1'b1;
    @(posedge clk); #1;
    release_cs = 1'b0;
    tests++; if (spi_ce_n !== 2'b11) begin fails++; $display("FAIL rel_ce_rise: got %b expected 11", spi_ce_n); end
    tests++; if (tx_ready !== 1'b0) begin fails++; $display("FAIL rel_gap_ready0: got %b expected 0", tx_ready); end
    @(posedge clk); #1;
    tests++; if (tx_ready !== 1'b0) begin fails++; $display("FAIL rel_gap_ready1: got %b expected 0", tx_ready); end
    @(posedge clk); #1;
    tests++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL rel_idle_ready: got %b expected 1", tx_ready); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rel_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_release_with_accept();
    logic [1:0] exp_ce;
    send(8'h3C, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
    repeat (18) begin @(posedge clk); #1; end
    release_cs = 1'b1;
    send(8'hC3, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    release_cs = 1'b0;
    tests++; if (spi_ce_n !== 2'b01) begin fails++; $display("FAIL relacc_ce: got %b expected 01", spi_ce_n); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL relacc_busy: got %b expected 1", busy); end
    for (int m = 1; m <= 19; m++) begin
      @(posedge clk); #1;
      exp_ce = (m <= 17) ? 2'b01 : 2'b11;
      tests++; if (spi_ce_n !== exp_ce) begin fails++; $display("FAIL relacc_ce m=%0d: got %b expected %b", m, spi_ce_n, exp_ce); end
      if (m == 18) begin
        tests++; if (rx_data !== 8'hC3) begin fails++; $display("FAIL relacc_rx_data: got %h expected c3", rx_data); end
      end
    end
  endtask

  task automatic test_async_reset();
    int vld_seen;
    vld_seen = 0;
    send(8'hFF, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    tests++; if (spi_ce_n !== 2'b11) begin fails++; $display("FAIL arst_ce_n: got %b expected 11", spi_ce_n); end
    tests++; if (spi_clk !== 1'b0) begin fails++; $display("FAIL arst_spi_clk: got %b expected 0", spi_clk); end
    tests++; if (spi_mosi !== 1'b0) begin fails++; $display("FAIL arst_mosi: got %b expected 0", spi_mosi); end
    tests++; if (rx_data !== 8'h00) begin fails++; $display("FAIL arst_rx_data: got %h expected 00", rx_data); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL arst_busy: got %b expected 0", busy); end
    #10;
    rst = 1'b0;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk); #1;
      if (rx_valid) vld_seen++;
    end
    tests++; if (vld_seen !== 0) begin fails++; $display("FAIL arst_no_rx_valid: got %0d pulses expected 0", vld_seen); end
    send(8'h5A, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    repeat (18) begin @(posedge clk); #1; end
    tests++; if (rx_valid !== 1'b1) begin fails++; $display("FAIL arst_next_valid: got %b expected 1", rx_valid); end
    tests++; if (rx_data !== 8'h5A) begin fails++; $display("FAIL arst_next_data: got %h expected 5a", rx_data); end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_bad_cs();
    logic prev;
    int   toggles;
    toggles = 0;
    tx_data = 8'hE7; cs_sel2 = 2'd3; cs_hold = 1'b0; cfg_div = 8'd0;
    cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_lsb_first = 1'b0;
    tx_valid2 = 1'b1;
    @(posedge clk); #1;
    tx_valid2 = 1'b0;
    prev = spi_clk2;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (spi_clk2 !== prev) toggles++;
      prev = spi_clk2;
      tests++; if (spi_ce_n2 !== 3'b111) begin fails++; $display("FAIL badcs_ce_n n=%0d: got %b expected 111", n, spi_ce_n2); end
      tests++; if (rx_valid2 !== (n == 18)) begin fails++; $display("FAIL badcs_rx_valid n=%0d: got %b expected %b", n, rx_valid2, (n == 18)); end
    end
    tests++; if (toggles !== 16) begin fails++; $display("FAIL badcs_toggles: got %0d expected 16", toggles); end
  endtask

  initial begin
    rst = 1'b1; tx_valid = 1'b0; tx_valid2 = 1'b0; tx_data = 8'h00; cs_sel = 1'b0; cs_sel2 = 2'd0;
    cs_hold = 1'b0; release_cs = 1'b0; cfg_div = 8'd0; cfg_cpol = 1'b0; cfg_cpha = 1'b0;
    cfg_lsb_first = 1'b0; loop_mode = 1'b1; slv_bit = 1'b0; slv_word = 8'h00; slv_cnt = 0;
    test_reset();
    test_loopback_mode0();
    test_mode3_lsb();
    test_hold();
    test_release();
    test_release_with_accept();
    test_async_reset();
    test_bad_cs();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
